md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit with HI/LO registers: the sequential companion of the single-cycle ALU in the execute stage. It accepts the same 32-bit `srcA`/`srcB` operand pair plus a 3-bit `MDOp` on a `start` pulse. It holds `busy` for a fixed latency and then commits results to HI/LO. The pipeline controller stalls any multiply/divide-class instruction in decode while `busy` or `start` is high.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu; legal range 1..31.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu; legal range 1..31.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled at the `clk` edge.
- `MDOp`  in  3  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 reserved, treated as none
- `srcA`  in  32  multiplicand / dividend / mthi and mtlo data.
- `srcB`  in  32  multiplier / divisor.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse on the cycle HI/LO commit.
- `HI`  out  32  HI register; read by mfhi.
- `LO`  out  32  LO register; read by mflo.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN: `start` high with `MDOp` in 1..4.
    - Operands and op are latched.
    - Counter is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
  - RUN: the counter decrements each edge. The edge where counter == 1:
    - commits HI/LO;
    - asserts `done` for the next cycle;
    - returns to IDLE.
- mthi / mtlo in IDLE with `start`: `HI`/`LO` ← `srcA` at that edge. Single cycle; no `busy`, no `done`.
- `start` while RUN: ignored entirely; no queueing, no abort. The controller guarantees this does not happen, and the bench checks that it is ignored.
- `start` with `MDOp` 0 or 7: no effect.
- Arithmetic:
  - mult: signed 32×32→64; `HI` = [63:32], `LO` = [31:0].
  - multu: the same, unsigned.
  - div: signed; `LO` = quotient truncated toward zero, `HI` = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `LO` = 0x80000000, `HI` = 0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): the operation runs its full latency and pulses `done`, but `HI`/`LO` are left unchanged.
- Results are computed from the latched operands. Operand changes after the `start` edge have no effect.

## Timing
- Reset (asynchronous, any time including mid-RUN):
  - state = IDLE, counter = 0;
  - `busy` = 0, `done` = 0, `HI` = 0, `LO` = 0;
  - the pending operation is discarded.
- Start accepted at edge E:
  - `busy` is high from E through E+N, where N is the op latency. `busy` is registered, so it is high for exactly N cycles.
  - `HI`/`LO` take the new values at edge E+N.
  - `done` is high for the cycle after E+N.
  - `busy` is low after E+N.
- A new `start` is accepted at E+N+1 at the earliest; back-to-back operations have no dead cycle beyond that.
- mthi/mtlo: `HI`/`LO` are visible the cycle after the `start` edge.

## Configuration
- `MD_UNIT_DIV_EN` defined: div and divu are implemented as described above.
- `MD_UNIT_DIV_EN` undefined:
  - no divider logic is synthesized;
  - `MDOp` 3/4 are treated as none: no `busy`, no `done`, HI/LO unchanged;
  - the `DIV_CYCLES` parameter is kept but unused.

## Structure
- Shared package `md_pkg`:
  - `MDOp` encodings as named localparams (`MD_NONE` … `MD_MTLO`);
  - FSM state encoding;
  - default latency constants.
- One sub-module, `md_core`: combinational 64-bit result generation from the latched op and operands. It is guarded internally by `MD_UNIT_DIV_EN` for the divide path.
- Top-level `md_unit` holds the FSM, counter, operand latches and HI/LO registers.

## Test plan
- Test 1: reset, then mult with `srcA` = 0xFFFFFFFF, `srcB` = 0x80000000.
  - `busy` is high for exactly 5 cycles.
  - Then `HI` = 0x00000000, `LO` = 0x80000000, and `done` pulses once.
- Test 2: multu with the same operands → `HI` = 0x7FFFFFFF, `LO` = 0x80000000 after 5 cycles.
- Test 3: div with `srcA` = 0xFFFFFFF9 (−7), `srcB` = 2.
  - `busy` is high for 10 cycles.
  - Then `LO` = 0xFFFFFFFD, `HI` = 0xFFFFFFFF.
- Test 4: mthi 0x12345678, mtlo 0x9ABCDEF0, then divu 7 / 0.
  - After 10 cycles `HI`/`LO` are still 0x12345678 / 0x9ABCDEF0, and `done` pulses.
- Test 5: start mult, then assert mtlo `start` 2 cycles later.
  - The mtlo is ignored and the mult result commits normally.
- Test 6: start div, assert `reset` asynchronously at cycle 4, mid-cycle.
  - `busy`, `HI` and `LO` go to 0 immediately.
  - No `done` follows.
  - A fresh mult is accepted after `reset` is released.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, latencies.
// The divide ops are accepted only when MD_UNIT_DIV_EN is defined.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_e;

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that occupy the unit for several cycles in this build.
    function automatic logic isLongOp(input logic [2:0] op);
`ifdef MD_UNIT_DIV_EN
        return (op == MD_MULT) || (op == MD_MULTU) || isDivOp(op);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit HI:LO result generation from the latched op and operands.
// Divide path present only when MD_UNIT_DIV_EN is defined.
module md_core
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        writeEn
);

    logic [63:0] extA_s;
    logic [63:0] extB_s;
    logic [63:0] prod_s;

    // Sign- or zero-extend so one 64-bit product serves both mult and multu.
    always_comb begin
        extA_s = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        extB_s = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    end

    assign prod_s = extA_s * extB_s;

`ifdef MD_UNIT_DIV_EN
    logic        signedOp_s;
    logic [31:0] magA_s;
    logic [31:0] magB_s;
    logic [31:0] safeB_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] divLo_s;
    logic [31:0] divHi_s;

    // Divide on magnitudes, then restore signs; avoids the MIN/-1 overflow case.
    always_comb begin
        signedOp_s = (op == MD_DIV);
        magA_s     = (signedOp_s && a[31]) ? (32'd0 - a) : a;
        magB_s     = (signedOp_s && b[31]) ? (32'd0 - b) : b;
        safeB_s    = (magB_s == 32'd0) ? 32'd1 : magB_s;
        quo_s      = magA_s / safeB_s;
        rem_s      = magA_s % safeB_s;
        divLo_s    = (signedOp_s && (a[31] ^ b[31])) ? (32'd0 - quo_s) : quo_s;
        divHi_s    = (signedOp_s && a[31]) ? (32'd0 - rem_s) : rem_s;
    end
`endif

    // Select the result; divide by zero leaves HI/LO untouched.
    always_comb begin
        result  = prod_s;
        writeEn = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                result  = prod_s;
                writeEn = 1'b1;
            end
`ifdef MD_UNIT_DIV_EN
            MD_DIV, MD_DIVU: begin
                result  = {divHi_s, divLo_s};
                writeEn = (b != 32'd0);
            end
`endif
            default: begin
                result  = prod_s;
                writeEn = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (FSM, counter, operand latches).
// Define MD_UNIT_DIV_EN to implement div/divu; otherwise MDOp 3/4 behave as none.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdState_e    state_r;
    mdState_e    stateNext_s;
    logic [4:0]  count_r;
    logic [2:0]  opLatch_r;
    logic [31:0] aLatch_r;
    logic [31:0] bLatch_r;
    logic        accept_s;
    logic        commit_s;
    logic        moveHi_s;
    logic        moveLo_s;
    logic [63:0] coreResult_s;
    logic        coreWrite_s;

    md_core uCore (
        .op      (opLatch_r),
        .a       (aLatch_r),
        .b       (bLatch_r),
        .result  (coreResult_s),
        .writeEn (coreWrite_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next state and per-edge control decisions; start is ignored while running.
    always_comb begin
        stateNext_s = state_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        moveHi_s    = 1'b0;
        moveLo_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && isLongOp(MDOp)) begin
                    accept_s    = 1'b1;
                    stateNext_s = RUN;
                end else if (start && (MDOp == MD_MTHI)) begin
                    moveHi_s    = 1'b1;
                end else if (start && (MDOp == MD_MTLO)) begin
                    moveLo_s    = 1'b1;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == 5'd1) begin
                    commit_s    = 1'b1;
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = RUN;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // Operand latches, latency counter and registered busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= 5'd0;
            opLatch_r <= MD_NONE;
            aLatch_r  <= 32'd0;
            bLatch_r  <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= commit_s;
            if (accept_s) begin
                opLatch_r <= MDOp;
                aLatch_r  <= srcA;
                bLatch_r  <= srcB;
                count_r   <= isDivOp(MDOp) ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                busy      <= 1'b1;
            end else if (state_r == RUN) begin
                count_r   <= count_r - 5'd1;
                busy      <= commit_s ? 1'b0 : 1'b1;
            end else begin
                busy      <= 1'b0;
            end
        end
    end

    // HI/LO: commit from the core, or direct moves while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else begin
            if (commit_s && coreWrite_s) begin
                HI <= coreResult_s[63:32];
            end else if (moveHi_s) begin
                HI <= srcA;
            end else begin
                HI <= HI;
            end
            if (commit_s && coreWrite_s) begin
                LO <= coreResult_s[31:0];
            end else if (moveLo_s) begin
                LO <= srcA;
            end else begin
                LO <= LO;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: cycle-level behavioural model plus directed literal checks.
// Divide tests adapt to whether MD_UNIT_DIV_EN is defined.
module tb_md_unit;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MD_UNIT_DIV_EN
    localparam int DIV_LAT  = 10;
    localparam int DIV_DONE = 1;
`else
    localparam int DIV_LAT  = 0;
    localparam int DIV_DONE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MDOp = 3'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;
    logic checkEn = 1'b0;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDOp  (MDOp),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mLeft = 0;
    logic        mDone = 1'b0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic        pendWr = 1'b0;
    logic [63:0] pendRes = 64'd0;

    function automatic int opLatency(input logic [2:0] op);
        if (op == OP_MULT || op == OP_MULTU) return 5;
        if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
        return 0;
    endfunction

    // {write, HI, LO} from plain integer arithmetic.
    function automatic logic [64:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint q;
        longint r;
        p = 0; q = 0; r = 0;
        if (op == OP_MULT) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            return {1'b1, p[63:0]};
        end else if (op == OP_MULTU) begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            return {1'b1, p[63:0]};
        end else if (b == 32'd0) begin
            return 65'd0;
        end else if (op == OP_DIV) begin
            q = longint'(signed'(a)) / longint'(signed'(b));
            r = longint'(signed'(a)) % longint'(signed'(b));
            return {1'b1, r[31:0], q[31:0]};
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
            return {1'b1, r[31:0], q[31:0]};
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mLeft  <= 0;
            mDone  <= 1'b0;
            mHi    <= 32'd0;
            mLo    <= 32'd0;
            pendWr <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (mLeft > 0) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mDone <= 1'b1;
                    if (pendWr) begin
                        mHi <= pendRes[63:32];
                        mLo <= pendRes[31:0];
                    end
                end
            end else if (start) begin
                if (opLatency(MDOp) > 0) begin
                    mLeft <= opLatency(MDOp);
                    {pendWr, pendRes} <= modelResult(MDOp, srcA, srcB);
                end else if (MDOp == OP_MTHI) begin
                    mHi <= srcA;
                end else if (MDOp == OP_MTLO) begin
                    mLo <= srcA;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("cyc busy", 32'(busy), 32'(mLeft > 0));
            check("cyc done", 32'(done), 32'(mDone));
            check("cyc HI", HI, mHi);
            check("cyc LO", LO, mLo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; MDOp = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0; srcA = $urandom; srcB = $urandom;
    endtask

    task automatic measure(input string nm, input int expBusy, input int expDone);
        int b = 0;
        int d = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) b++;
            if (done) d++;
            @(negedge clk);
        end
        check({nm, " busy cycles"}, 32'(b), 32'(expBusy));
        check({nm, " done pulses"}, 32'(d), 32'(expDone));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        reset = 1'b0;
        checkEn = 1'b1;

        // Test 1: signed mult
        issue(OP_MULT, 32'hFFFFFFFF, 32'h80000000);
        measure("t1", 5, 1);
        check("t1 HI", HI, 32'h00000000);
        check("t1 LO", LO, 32'h80000000);

        // Test 2: unsigned mult
        issue(OP_MULTU, 32'hFFFFFFFF, 32'h80000000);
        measure("t2", 5, 1);
        check("t2 HI", HI, 32'h7FFFFFFF);
        check("t2 LO", LO, 32'h80000000);

        // Test 3: signed div (ignored without the divider)
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        measure("t3", DIV_LAT, DIV_DONE);
`ifdef MD_UNIT_DIV_EN
        check("t3 HI", HI, 32'hFFFFFFFF);
        check("t3 LO", LO, 32'hFFFFFFFD);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        measure("t3b", 10, 1);
        check("t3b HI", HI, 32'h00000000);
        check("t3b LO", LO, 32'h80000000);
        issue(OP_DIVU, 32'hFFFFFFFF, 32'h00000010);
        measure("t3c", 10, 1);
        check("t3c HI", HI, 32'h0000000F);
        check("t3c LO", LO, 32'h0FFFFFFF);
`else
        check("t3 HI", HI, 32'h7FFFFFFF);
        check("t3 LO", LO, 32'h80000000);
`endif

        // Test 4: moves, then divu by zero leaves HI/LO
        issue(OP_MTHI, 32'h12345678, 32'd0);
        check("t4 mthi", HI, 32'h12345678);
        check("t4 mthi busy", 32'(busy), 32'd0);
        issue(OP_MTLO, 32'h9ABCDEF0, 32'd0);
        check("t4 mtlo", LO, 32'h9ABCDEF0);
        issue(OP_DIVU, 32'd7, 32'd0);
        measure("t4", DIV_LAT, DIV_DONE);
        check("t4 HI", HI, 32'h12345678);
        check("t4 LO", LO, 32'h9ABCDEF0);

        // Test 5: mtlo two cycles into a mult is ignored
        issue(OP_MULT, 32'h00010000, 32'h00010000);
        @(negedge clk);
        start = 1'b1; MDOp = OP_MTLO; srcA = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        measure("t5", 3, 1);
        check("t5 HI", HI, 32'h00000001);
        check("t5 LO", LO, 32'h00000000);

        // Back-to-back: second start at the earliest accepting edge
        issue(OP_MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        issue(OP_MULTU, 32'd9, 32'd11);
        measure("b2b", 5, 1);
        check("b2b LO", LO, 32'd99);

        // Test 6: async reset mid-operation
`ifdef MD_UNIT_DIV_EN
        issue(OP_DIV, 32'd100, 32'd7);
`else
        issue(OP_MULT, 32'd100, 32'd7);
`endif
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 HI", HI, 32'd0);
        check("t6 LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        measure("t6 idle", 0, 0);
        issue(OP_MULT, 32'd3, 32'd4);
        measure("t6 mult", 5, 1);
        check("t6 mult HI", HI, 32'd0);
        check("t6 mult LO", LO, 32'd12);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
